spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
Byte-wide SPI master: SPI mode 0 (CPOL=0, CPHA=0), MSB first, one fixed slave select. A local controller pulses start with a byte on tx_data. The block shifts that byte out on mosi, shifts in 8 bits from miso, and returns them on rx_data with a one-cycle done pulse. It sits between the system-clock domain and the off-chip SPI pins.

Parameters:
CLK_DIV, 4, clk cycles per SCLK period; even and >= 2; sclk toggles every CLK_DIV/2 clk cycles.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  transfer request, sampled on clk rising edge
tx_data  input  8  byte to transmit, captured when start is accepted
rx_data  output  8  last received byte, valid from the done cycle, held until next done
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse at transfer completion
sclk  output  1  SPI clock, idle low
mosi  output  1  serial data out, MSB first
miso  input  1  serial data in
cs_n  output  1  active-low slave select

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async, immediate, also mid-transfer): state IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=8'h00, shift/bit/divider counters=0. After reset release, the block waits for a fresh start; no partial transfer completes.
- FSM states: IDLE, XFER, DONE.
- IDLE: sclk=0, cs_n=1, busy=0, mosi=0.
- IDLE, start=1 at edge E0:
  - tx shift reg <= tx_data
  - mosi <= tx_data[7]
  - cs_n <= 0, busy <= 1
  - divider and bit counter cleared
  - -> XFER
- XFER:
  - Divider counts clk cycles; every CLK_DIV/2 cycles sclk toggles.
  - Rising sclk: sample miso into rx shift reg LSB (shift left).
  - Falling sclk, bits remaining: mosi <= next tx bit (MSB-first order).
  - 8th falling edge (16th toggle), at E0 + 8*CLK_DIV: sclk=0, cs_n <= 1, busy <= 0, done <= 1, rx_data <= assembled byte -> DONE.
- DONE: lasts exactly one cycle. done <= 0, mosi <= 0 -> IDLE.
- Latency: with CLK_DIV=4, done is high in the cycle 32 clks after the start edge. The next transfer can be accepted one cycle after done.
- start while busy=1 or in DONE: ignored, with no effect on the current transfer.
- tx_data changes after the start edge: ignored.
- start held high continuously: a new transfer starts on each return to IDLE.
- Bit alignment: first received bit (miso at first rising sclk) lands in rx_data[7]; last received bit lands in rx_data[0].
- Setup: mosi is stable >= CLK_DIV/2 clk cycles before each rising sclk. cs_n falls CLK_DIV/2 cycles before the first rising sclk.
- rx_data changes only in the done cycle.

Test Plan:
- Reset: assert rst_n=0 mid-idle and mid-transfer -> sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=8'h00 immediately; no done pulse afterwards.
- Loopback (miso=mosi), tx_data=8'hA5, CLK_DIV=4 -> busy high from next cycle; exactly 8 sclk pulses; done pulse 32 clks after start edge; rx_data=8'hA5; cs_n high at done.
- Slave model returns 8'h3C while tx_data=8'hFF -> mosi bit sequence 1,1,1,1,1,1,1,1; rx_data=8'h3C.
- miso tied 0, tx_data=8'h81 -> mosi sequence 1,0,0,0,0,0,0,1 (MSB first); rx_data=8'h00.
- start re-pulsed mid-transfer with tx_data=8'h00 -> ignored; the original byte completes; a single done pulse.
- Back-to-back: 8'h12 then 8'h34 in loopback, start reissued right after done -> two done pulses; rx_data=8'h12 then 8'h34; cs_n deasserts between transfers.

Source files
------------

// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, single slave select.
// A start pulse in idle launches one 8-bit full-duplex transfer; done pulses for one cycle at the end.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] tx_data_i,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       cs_n_o
);

  localparam int unsigned Half = CLK_DIV / 2;
  localparam int unsigned DivW = (Half > 1) ? $clog2(Half) : 1;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = done_q;

    unique case (state_q)
      StIdle: begin
        sclk_d = 1'b0;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        mosi_d = 1'b0;
        done_d = 1'b0;
        if (start_i) begin
          tx_sh_d = tx_data_i;
          mosi_d  = tx_data_i[7];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          rx_sh_d = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (div_q == DivW'(Half - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising sclk: slave data is sampled, shifting in MSB first.
            rx_sh_d = {rx_sh_q[6:0], miso_i};
          end else if (bit_q == 3'd7) begin
            // 8th falling edge ends the transfer.
            cs_n_d    = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = rx_sh_q;
            bit_d     = '0;
            state_d   = StDone;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b0;
        mosi_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table of transfers with a scoreboard of expected rx bytes,
// plus hand sequences for mid-transfer start, back-to-back start and async reset.
module tb_spi_master;

  localparam int unsigned ClkDiv  = 4;
  localparam int          Latency = 8 * ClkDiv;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       busy, done, sclk, mosi, miso, cs_n;

  logic       loop_mode = 1'b1;
  logic [7:0] slave_sh = 8'h00;
  logic [7:0] mosi_bits = 8'h00;
  int         pulses = 0;
  int         done_cnt = 0;
  int         tests = 0;
  int         failed = 0;
  logic [7:0] exp_q[$];

  spi_master #(.CLK_DIV(ClkDiv)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .tx_data_i(tx_data),
    .rx_data_o(rx_data),
    .busy_o   (busy),
    .done_o   (done),
    .sclk_o   (sclk),
    .mosi_o   (mosi),
    .miso_i   (miso),
    .cs_n_o   (cs_n)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: presents its MSB before the first rising sclk, shifts on falling sclk.
  assign miso = loop_mode ? mosi : slave_sh[7];

  always @(posedge sclk) begin
    mosi_bits = {mosi_bits[6:0], mosi};
    pulses    = pulses + 1;
  end

  always @(negedge sclk) slave_sh = {slave_sh[6:0], 1'b0};

  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      failed = failed + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts cycles after the start edge until done; the scoreboard is checked on done.
  task automatic wait_done(output int cyc);
    logic [7:0] e;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc = cyc + 1;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e});
        end
        return;
      end
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_edge(input logic [7:0] tx);
    @(negedge clk);
    start   = 1'b1;
    tx_data = tx;
    @(posedge clk); #1;
    start   = 1'b0;
    tx_data = ~tx;
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic mode, input logic [7:0] sbyte,
                          input logic [7:0] exp_rx);
    int cyc;
    loop_mode = mode;
    slave_sh  = sbyte;
    pulses    = 0;
    mosi_bits = 8'h00;
    exp_q.push_back(exp_rx);
    start_edge(tx);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("cs_n_after_start", {31'd0, cs_n}, 32'd0);
    check("mosi_first_bit", {31'd0, mosi}, {31'd0, tx[7]});
    wait_done(cyc);
    check("latency", cyc, Latency);
    check("sclk_pulses", pulses, 32'd8);
    check("mosi_bits", {24'd0, mosi_bits}, {24'd0, tx});
    check("cs_n_at_done", {31'd0, cs_n}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("sclk_at_done", {31'd0, sclk}, 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("mosi_idle", {31'd0, mosi}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, {31'd0, sclk}, 32'd0);
    check({tag, "_cs_n"}, {31'd0, cs_n}, 32'd1);
    check({tag, "_mosi"}, {31'd0, mosi}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_rx"}, {24'd0, rx_data}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       loopback;
    logic [7:0] slave_byte;
    logic [7:0] exp_rx;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   cyc, d0;

    vecs[0] = '{tx: 8'hA5, loopback: 1'b1, slave_byte: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hFF, loopback: 1'b0, slave_byte: 8'h3C, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h81, loopback: 1'b0, slave_byte: 8'h00, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'h12, loopback: 1'b1, slave_byte: 8'h00, exp_rx: 8'h12};
    vecs[4] = '{tx: 8'h34, loopback: 1'b0, slave_byte: 8'hC7, exp_rx: 8'hC7};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].tx, vecs[i].loopback, vecs[i].slave_byte, vecs[i].exp_rx);
    end

    // Start re-pulsed mid-transfer with 8'h00 must not disturb the byte in flight.
    loop_mode = 1'b1;
    pulses    = 0;
    mosi_bits = 8'h00;
    d0        = done_cnt;
    exp_q.push_back(8'h5A);
    start_edge(8'h5A);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start   = 1'b1;
    tx_data = 8'h00;
    @(negedge clk);
    start   = 1'b0;
    wait_done(cyc);
    check("ignored_start_latency", cyc, Latency - 10);
    check("ignored_start_mosi", {24'd0, mosi_bits}, 32'h5A);
    repeat (4) @(posedge clk);
    #1;
    check("ignored_start_one_done", done_cnt - d0, 32'd1);
    check("ignored_start_idle", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high: second byte is taken on return to idle.
    pulses = 0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    @(negedge clk);
    start   = 1'b1;
    tx_data = 8'h12;
    @(posedge clk); #1;
    tx_data = 8'h34;
    wait_done(cyc);
    check("b2b_first_latency", cyc, Latency);
    @(posedge clk); #1;
    check("b2b_cs_n_gap", {31'd0, cs_n}, 32'd1);
    check("b2b_busy_gap", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    repeat (16) @(posedge clk);
    #1;
    check("b2b_rx_held", {24'd0, rx_data}, 32'h12);
    wait_done(cyc);
    check("b2b_second_latency", cyc, Latency - 16);
    check("b2b_pulses", pulses, 32'd16);

    // Async reset in idle with a non-zero rx_data.
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("idle_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-transfer: outputs clear at once and no done follows.
    loop_mode = 1'b1;
    start_edge(8'hC3);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("xfer_rst");
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt - d0, 32'd0);
    check("idle_after_rst", {31'd0, busy}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
